// File: rtl/seq_comparator.sv
// Bit-serial magnitude comparator: scans the captured operands from MSB to
// LSB, one bit pair per clock, and stops at the first differing bit.
module seq_comparator #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             busy,
   output logic             valid,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic             sgn_q,   sgn_d;
   logic             valid_q, valid_d;
   logic             lt_q,    lt_d;
   logic             eq_q,    eq_d;
   logic             gt_q,    gt_d;

   logic             bit_diff;
   logic             at_msb;
   logic             a_greater;

   // Next-state and result computation for the current bit pair
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      valid_d = 1'b0;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;

      bit_diff  = a_q[idx_q] ^ b_q[idx_q];
      at_msb    = (idx_q == IDX_W'(WIDTH - 1));
      // The sign bit inverts the sense of the comparison in signed mode
      a_greater = a_q[idx_q] ^ (at_msb & sgn_q);

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sgn_d   = is_signed;
               idx_d   = IDX_W'(WIDTH - 1);
               state_d = RUN;
            end
         end
         RUN: begin
            if (bit_diff) begin
               lt_d    = ~a_greater;
               gt_d    = a_greater;
               eq_d    = 1'b0;
               valid_d = 1'b1;
               state_d = IDLE;
            end else if (idx_q == '0) begin
               lt_d    = 1'b0;
               gt_d    = 1'b0;
               eq_d    = 1'b1;
               valid_d = 1'b1;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= IDX_W'(WIDTH - 1);
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         valid_q <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         valid_q <= valid_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign valid = valid_q;
   assign lt    = lt_q;
   assign eq    = eq_q;
   assign gt    = gt_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: a 4-bit and an 8-bit instance checked every cycle
// against an arithmetic model, plus directed cases with literal expectations.
module tb_seq_comparator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       start4 = 1'b0, sg4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, valid4, lt4, eq4, gt4;

   logic       start8 = 1'b0, sg8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, valid8, lt8, eq8, gt8;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   // model state per instance (0: WIDTH=4, 1: WIDTH=8)
   logic       m_busy  [2] = '{1'b0, 1'b0};
   logic       m_valid [2] = '{1'b0, 1'b0};
   logic [2:0] m_res   [2] = '{3'b000, 3'b000};
   logic [2:0] m_pend  [2] = '{3'b000, 3'b000};
   int         m_left  [2] = '{0, 0};

   localparam logic [2:0] R_LT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_GT = 3'b001;

   seq_comparator #(.WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .is_signed(sg4),
      .busy(busy4), .valid(valid4), .lt(lt4), .eq(eq4), .gt(gt4));

   seq_comparator #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .is_signed(sg8),
      .busy(busy8), .valid(valid8), .lt(lt8), .eq(eq8), .gt(gt8));

   always #5 clk = ~clk;

   function automatic int width_of(input int n);
      return (n == 0) ? 4 : 8;
   endfunction

   // {busy, valid, lt, eq, gt}
   function automatic logic [4:0] outs(input int n);
      return (n == 0) ? {busy4, valid4, lt4, eq4, gt4} : {busy8, valid8, lt8, eq8, gt8};
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic set_in(input int n, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic sg);
      if (n == 0) begin
         start4 = st; a4 = a[3:0]; b4 = b[3:0]; sg4 = sg;
      end else begin
         start8 = st; a8 = a[7:0]; b8 = b[7:0]; sg8 = sg;
      end
   endtask

   // Expected result by plain arithmetic; latency from the highest differing bit
   task automatic model_cmp(input int w, input logic [31:0] a, input logic [31:0] b,
                            input logic sg, output logic [2:0] res, output int lat);
      longint ua, ub, sa, sb;
      ua = longint'(a) & ((longint'(1) << w) - 1);
      ub = longint'(b) & ((longint'(1) << w) - 1);
      sa = (sg && ua[w-1]) ? ua - (longint'(1) << w) : ua;
      sb = (sg && ub[w-1]) ? ub - (longint'(1) << w) : ub;
      res = (sa < sb) ? R_LT : (sa == sb) ? R_EQ : R_GT;
      lat = w;
      for (int i = 0; i < w; i++)
         if (ua[i] != ub[i]) lat = w - i;
   endtask

   // Cycle-level model of both instances
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < 2; n++) begin
            m_busy[n] = 1'b0; m_valid[n] = 1'b0; m_res[n] = 3'b000; m_left[n] = 0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            logic        st, sg;
            logic [31:0] a, b;
            logic [2:0]  r;
            int          lat;
            st = (n == 0) ? start4 : start8;
            a  = (n == 0) ? 32'(a4) : 32'(a8);
            b  = (n == 0) ? 32'(b4) : 32'(b8);
            sg = (n == 0) ? sg4 : sg8;
            m_valid[n] = 1'b0;
            if (m_busy[n]) begin
               m_left[n]--;
               if (m_left[n] == 0) begin
                  m_busy[n]  = 1'b0;
                  m_valid[n] = 1'b1;
                  m_res[n]   = m_pend[n];
               end
            end else if (st) begin
               model_cmp(width_of(n), a, b, sg, r, lat);
               m_pend[n] = r;
               m_left[n] = lat;
               m_busy[n] = 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison of both DUTs against the model
   always @(negedge clk) begin
      if (chk_on) begin
         for (int n = 0; n < 2; n++) begin
            logic [4:0] o;
            o = outs(n);
            chk($sformatf("cycle_outs_w%0d", width_of(n)), int'(o),
                int'({m_busy[n], m_valid[n], m_res[n]}));
            if (o[3]) chk($sformatf("onehot_w%0d", width_of(n)), int'($countones(o[2:0])), 1);
         end
      end
   end

   // One comparison: accept, scramble inputs, wait for valid, check latency/result
   task automatic do_cmp(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input int exp_lat, input logic [2:0] exp_res,
                         input string name);
      int got;
      logic [4:0] o;
      got = -1;
      @(negedge clk);
      set_in(n, 1'b1, a, b, sg);
      @(negedge clk);
      set_in(n, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         o = outs(n);
         if (o[3] && got < 0) got = c;
         if (got > 0) break;
      end
      o = outs(n);
      if (exp_lat > 0) begin
         chk({name, "_lat"}, got, exp_lat);
         chk({name, "_res"}, int'(o[2:0]), int'(exp_res));
      end else begin
         chk({name, "_done"}, int'(got > 0), 1);
      end
   endtask

   initial begin
      int c;
      logic [4:0] o;
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_w4", int'(outs(0)), 0);
      chk("reset_w8", int'(outs(1)), 0);
      @(negedge clk);
      #2 reset = 1'b1;
      chk_on = 1'b1;

      do_cmp(0, 32'h3, 32'hF, 1'b0, 1, R_LT, "u3_vs_F");
      do_cmp(0, 32'h3, 32'hF, 1'b1, 1, R_GT, "s3_vs_F");
      do_cmp(0, 32'h5, 32'h5, 1'b0, 4, R_EQ, "eq5");
      do_cmp(0, 32'h4, 32'h5, 1'b0, 4, R_LT, "u4_vs_5");
      do_cmp(0, 32'h6, 32'h2, 1'b0, 2, R_GT, "u6_vs_2");
      do_cmp(0, 32'h8, 32'h7, 1'b1, 1, R_LT, "s8_vs_7");
      do_cmp(1, 32'h80, 32'h7F, 1'b1, 1, R_LT, "s80_vs_7F");
      do_cmp(1, 32'h80, 32'h7F, 1'b0, 1, R_GT, "u80_vs_7F");
      do_cmp(1, 32'hA5, 32'hA4, 1'b1, 8, R_GT, "sA5_vs_A4");
      do_cmp(1, 32'hFF, 32'hFF, 1'b1, 8, R_EQ, "eqFF");

      // start re-pulsed during RUN is ignored; start in the valid cycle is taken
      @(negedge clk);
      set_in(0, 1'b1, 32'h4, 32'h5, 1'b0);
      @(negedge clk);
      set_in(0, 1'b1, 32'hF, 32'h5, 1'b0);
      c = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         set_in(0, 1'b0, 32'hF, 32'h5, 1'b0);
         if (valid4) begin c = i; break; end
      end
      chk("ignore_start_lat", c, 4);
      chk("ignore_start_res", int'({lt4, eq4, gt4}), int'(R_LT));
      set_in(0, 1'b1, 32'h3, 32'hF, 1'b0);
      @(negedge clk);
      set_in(0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("b2b_busy_valid", int'({busy4, valid4}), 2);
      chk("b2b_hold_res", int'({lt4, eq4, gt4}), int'(R_LT));
      @(negedge clk);
      chk("b2b_res", int'({valid4, lt4, eq4, gt4}), int'({1'b1, R_LT}));

      // reset mid-RUN aborts with outputs zeroed at once
      @(negedge clk);
      set_in(1, 1'b1, 32'h33, 32'h33, 1'b0);
      @(negedge clk);
      set_in(1, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("pre_abort_busy", int'(busy8), 1);
      #2 reset = 1'b0;
      #1;
      chk("abort_w8", int'(outs(1)), 0);
      chk("abort_w4", int'(outs(0)), 0);
      @(negedge clk);
      #2 reset = 1'b1;
      o = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         o = o | outs(1);
      end
      chk("no_valid_after_abort", int'(o), 0);
      do_cmp(1, 32'h80, 32'h7F, 1'b1, 1, R_LT, "post_reset");

      // randomised cases checked by the per-cycle model
      for (int i = 0; i < 12; i++) begin
         do_cmp(0, $urandom_range(0, 15), $urandom_range(0, 15),
                1'($urandom_range(0, 1)), -1, R_EQ, "rand_w4");
         do_cmp(1, $urandom_range(0, 255), $urandom_range(0, 255),
                1'($urandom_range(0, 1)), -1, R_EQ, "rand_w8");
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8 (legal range 2..32), giving the operand width in bits.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge or on reset assertion.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 SHALL immediately force the reset state.
REQ-004 start  input  1  request to begin a comparison; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 is_signed  input  1  1 = two's-complement compare, 0 = unsigned compare; captured when start is accepted.
REQ-008 busy  output  1  high while a comparison is in progress.
REQ-009 valid  output  1  one-cycle pulse marking a new result on lt/eq/gt.
REQ-010 lt  output  1  captured a < captured b, under the captured mode.
REQ-011 eq  output  1  captured a == captured b.
REQ-012 gt  output  1  captured a > captured b, under the captured mode.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL latch a, b and is_signed, set bit index to WIDTH-1, and enter RUN; busy SHALL be 1 from the next cycle.
REQ-015 In IDLE with start=0, the state and all outputs except valid SHALL hold.
REQ-016 In RUN, each clock edge SHALL examine exactly one bit pair at the current index, scanning from MSB to LSB.
REQ-017 If the bits differ at index WIDTH-1 and the captured is_signed is 1: the operand with bit 1 SHALL be the lesser (a bit 1 gives lt=1; b bit 1 gives gt=1).
REQ-018 If the bits differ at any other index, or at index WIDTH-1 with is_signed=0: the operand with bit 1 SHALL be the greater.
REQ-019 On the first differing bit, the block SHALL terminate early at that edge: update lt/eq/gt, pulse valid, clear busy, and return to IDLE.
REQ-020 If the bits at index 0 are equal and no earlier bits differed, the block SHALL set eq=1, lt=0, gt=0, pulse valid, and return to IDLE.
REQ-021 Otherwise the index SHALL decrement by 1 and the block SHALL stay in RUN.
REQ-022 Latency SHALL be k edges from the accepting edge to the edge that asserts valid, where k = WIDTH - i, i = index of the first differing bit; for equal operands, k = WIDTH.
REQ-023 Exactly one of lt/eq/gt SHALL be 1 whenever valid=1.
REQ-024 lt/eq/gt SHALL hold their last result until the next valid pulse, and SHALL NOT change on acceptance of a new start.
REQ-025 valid SHALL be high for exactly one cycle per comparison and SHALL never be high while busy=1.
REQ-026 start SHALL be ignored while in RUN; captured operands and mode SHALL NOT change mid-comparison.
REQ-027 In the cycle where valid=1 the FSM is in IDLE, so start=1 SHALL be accepted, allowing back-to-back comparisons with no dead cycle.
REQ-028 Changes on a, b or is_signed after acceptance SHALL have no effect on the result in progress.

Reset
REQ-029 While reset=0: state=IDLE, busy=0, valid=0, lt=0, eq=0, gt=0, index=WIDTH-1, captured operands=0.
REQ-030 Reset asserted mid-RUN SHALL abort the comparison immediately, with no valid pulse and no update of the captured result.
REQ-031 After reset deasserts, the first start SHALL be accepted on the first rising edge at which reset=1 and start=1.

Verification
REQ-032 WIDTH=4, a=4'h3, b=4'hF, is_signed=0, one-cycle start -> valid 1 edge after accept, lt=1, eq=0, gt=0.
REQ-033 WIDTH=4, a=4'h3, b=4'hF, is_signed=1 -> valid 1 edge after accept, gt=1 (3 > -1).
REQ-034 WIDTH=4, a=b=4'h5 -> busy high for 4 cycles, valid 4 edges after accept, eq=1; separately a=4'h4, b=4'h5 -> valid after 4 edges, lt=1.
REQ-035 WIDTH=4, a=4'h4, b=4'h5; re-pulse start with a=4'hF during RUN -> start ignored, result lt=1; start held high in the valid cycle -> second comparison accepted immediately.
REQ-036 WIDTH=8, a=8'h80, b=8'h7F, signed, then unsigned -> lt=1, then gt=1; drive reset=0 one cycle after an accept with equal operands -> busy=0 and outputs zero at once, no valid pulse.
